// File: rtl/pkt_pkg.sv
// Shared packet definitions for the node datapath: packet types, header layout,
// sequence width and transmit FSM states.
package pkt_pkg;

  localparam int unsigned SEQ_WIDTH  = 8;
  localparam int unsigned TYPE_WIDTH = 3;
  localparam int unsigned HDR_WIDTH  = 16;
  localparam int unsigned IDX_WIDTH  = 3;

  localparam logic [TYPE_WIDTH-1:0] PKT_HB   = 3'd1;
  localparam logic [TYPE_WIDTH-1:0] PKT_CHE  = 3'd2;
  localparam logic [TYPE_WIDTH-1:0] PKT_CHA  = 3'd3;
  localparam logic [TYPE_WIDTH-1:0] PKT_MEM  = 3'd4;
  localparam logic [TYPE_WIDTH-1:0] PKT_DATA = 3'd5;

  // Header word: type[15:13], role[12], low_E[11], iHaveData[10], rsvd[9:8], seq[7:0]
  typedef struct packed {
    logic [TYPE_WIDTH-1:0] ptype;
    logic                  role;
    logic                  low_e;
    logic                  have_data;
    logic [1:0]            rsvd;
    logic [SEQ_WIDTH-1:0]  seq;
  } pkt_hdr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } pkt_state_e;

  function automatic logic type_is_legal(input logic [TYPE_WIDTH-1:0] t);
    logic legal;
    case (t)
      PKT_HB, PKT_CHE, PKT_CHA, PKT_MEM, PKT_DATA: legal = 1'b1;
      default:                                     legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/pkt_csum.sv
// XOR checksum accumulator with synchronous clear and accumulate enable;
// shared between the transmit assembler and the receive-side checker.
module pkt_csum #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] csum
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  // Clear wins over accumulate
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q ^ din;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign csum = acc_q;

endmodule

// File: rtl/pkt_tx.sv
// Outgoing packet assembler: snapshots node state on request acceptance and
// streams header, state words, optional payload and an XOR checksum word.
module pkt_tx
  import pkt_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TYPE_WIDTH-1:0] req_type,
  input  logic [WORD_WIDTH-1:0] req_dest,
  input  logic [WORD_WIDTH-1:0] req_payload,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] hopsFromSink,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic                  role,
  input  logic                  low_E,
  input  logic                  iHaveData,
  output logic                  tx_valid,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  req_err
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX_SHORT = IDX_WIDTH'(6);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX_DATA  = IDX_WIDTH'(7);

  pkt_state_e            state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [WORD_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_last_q, tx_last_d;
  logic                  busy_q, busy_d;
  logic                  req_err_q, req_err_d;

  logic [WORD_WIDTH-1:0] id_q, id_d;
  logic [WORD_WIDTH-1:0] dest_q, dest_d;
  logic [WORD_WIDTH-1:0] hops_q, hops_d;
  logic [WORD_WIDTH-1:0] energy_q, energy_d;
  logic [WORD_WIDTH-1:0] qval_q, qval_d;
  logic [WORD_WIDTH-1:0] payload_q, payload_d;
  logic                  is_data_q, is_data_d;

  logic                  legal_c;
  logic                  accept_c;
  logic                  handshake_c;
  logic                  csum_clr_c;
  logic [IDX_WIDTH-1:0]  idx_nxt_c;
  logic [IDX_WIDTH-1:0]  last_idx_c;
  logic [WORD_WIDTH-1:0] next_word_c;
  logic [WORD_WIDTH-1:0] csum_c;
  pkt_hdr_t              hdr_c;

  assign req_ready   = en & ~busy_q;
  assign legal_c     = type_is_legal(req_type);
  assign accept_c    = req_valid & req_ready & legal_c;
  assign handshake_c = tx_valid_q & tx_ready;
  assign csum_clr_c  = accept_c;
  assign idx_nxt_c   = idx_q + IDX_WIDTH'(1);
  assign last_idx_c  = is_data_q ? LAST_IDX_DATA : LAST_IDX_SHORT;

  pkt_csum #(
    .WIDTH (WORD_WIDTH)
  ) u_csum (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (csum_clr_c),
    .acc_en (handshake_c),
    .din    (tx_data_q),
    .csum   (csum_c)
  );

  always_comb begin
    hdr_c           = '0;
    hdr_c.ptype     = req_type;
    hdr_c.role      = role;
    hdr_c.low_e     = low_E;
    hdr_c.have_data = iHaveData;
    hdr_c.seq       = seq_q;
  end

  // Snapshot word selected for the next body position
  always_comb begin
    next_word_c = '0;
    case (idx_nxt_c)
      IDX_WIDTH'(1): next_word_c = id_q;
      IDX_WIDTH'(2): next_word_c = dest_q;
      IDX_WIDTH'(3): next_word_c = hops_q;
      IDX_WIDTH'(4): next_word_c = energy_q;
      IDX_WIDTH'(5): next_word_c = qval_q;
      IDX_WIDTH'(6): next_word_c = payload_q;
      default:       next_word_c = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_last_d  = tx_last_q;
    busy_d     = busy_q;
    req_err_d  = req_valid & req_ready & ~legal_c;
    id_d       = id_q;
    dest_d     = dest_q;
    hops_d     = hops_q;
    energy_d   = energy_q;
    qval_d     = qval_q;
    payload_d  = payload_q;
    is_data_d  = is_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d    = ST_SEND;
          idx_d      = '0;
          seq_d      = seq_q + SEQ_WIDTH'(1);
          tx_valid_d = 1'b1;
          tx_data_d  = WORD_WIDTH'(hdr_c);
          tx_last_d  = 1'b0;
          busy_d     = 1'b1;
          id_d       = myNodeID;
          dest_d     = req_dest;
          hops_d     = hopsFromSink;
          energy_d   = myEnergy;
          qval_d     = myQValue;
          payload_d  = req_payload;
          is_data_d  = (req_type == PKT_DATA);
        end
      end
      ST_SEND: begin
        if (handshake_c) begin
          if (tx_last_q) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
            tx_last_d  = 1'b0;
            busy_d     = 1'b0;
          end else begin
            idx_d = idx_nxt_c;
            // Accumulator excludes the word being handshaked now, so fold it in
            if (idx_nxt_c == last_idx_c) begin
              tx_data_d = csum_c ^ tx_data_q;
              tx_last_d = 1'b1;
            end else begin
              tx_data_d = next_word_c;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      seq_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      req_err_q  <= 1'b0;
      id_q       <= '0;
      dest_q     <= '0;
      hops_q     <= '0;
      energy_q   <= '0;
      qval_q     <= '0;
      payload_q  <= '0;
      is_data_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
      req_err_q  <= req_err_d;
      id_q       <= id_d;
      dest_q     <= dest_d;
      hops_q     <= hops_d;
      energy_q   <= energy_d;
      qval_q     <= qval_d;
      payload_q  <= payload_d;
      is_data_q  <= is_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign tx_last  = tx_last_q;
  assign busy     = busy_q;
  assign req_err  = req_err_q;

endmodule

// File: tb/tb_pkt_tx.sv
// Scoreboard bench for pkt_tx: a packet-level reference model queues expected
// words at acceptance; a negedge monitor checks every handshaked word.
module tb_pkt_tx;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [15:0] req_dest, req_payload;
  logic [15:0] myNodeID, hopsFromSink, myEnergy, myQValue;
  logic        role, low_E, iHaveData;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_last;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        req_err;

  typedef struct {
    logic [15:0] data;
    logic        first;
    logic        last;
    int          acc_cyc;
    int          len;
    bit          timed;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          seq_model = 0;
  int          last_acc_cyc = 0;
  bit          rand_ready = 1'b0;
  logic        ready_force = 1'b1;
  bit          btb = 1'b0;
  bit          have_last = 1'b0;
  int          last_cyc = 0;
  bit          stall_prev = 1'b0;
  logic [15:0] stall_data;
  logic        stall_last;

  pkt_tx #(.WORD_WIDTH(16)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_type     (req_type),
    .req_dest     (req_dest),
    .req_payload  (req_payload),
    .myNodeID     (myNodeID),
    .hopsFromSink (hopsFromSink),
    .myEnergy     (myEnergy),
    .myQValue     (myQValue),
    .role         (role),
    .low_E        (low_E),
    .iHaveData    (iHaveData),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .req_err      (req_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference packet: header fields by arithmetic, body in fixed order, XOR of all as trailer
  task automatic push_model(input int t, input int dest, input int pay, input int id, input int hops,
                            input int energy, input int q, input int r, input int le, input int hd,
                            input int seq, input int acc, input bit timed);
    logic [15:0] w[$];
    logic [15:0] cs;
    exp_t e;
    w.push_back(16'(t * 8192 + r * 4096 + le * 2048 + hd * 1024 + seq));
    w.push_back(16'(id));
    w.push_back(16'(dest));
    w.push_back(16'(hops));
    w.push_back(16'(energy));
    w.push_back(16'(q));
    if (t == 5) w.push_back(16'(pay));
    cs = 16'h0;
    foreach (w[i]) cs = cs ^ w[i];
    w.push_back(cs);
    foreach (w[i]) begin
      e.data = w[i]; e.first = (i == 0); e.last = (i == w.size() - 1);
      e.acc_cyc = acc; e.len = w.size(); e.timed = timed;
      exp_q.push_back(e);
    end
  endtask

  task automatic randomize_node();
    myNodeID = 16'($urandom); hopsFromSink = 16'($urandom);
    myEnergy = 16'($urandom); myQValue = 16'($urandom);
    req_dest = 16'($urandom); req_payload = 16'($urandom);
    role = 1'($urandom); low_E = 1'($urandom); iHaveData = 1'($urandom);
  endtask

  // Present a legal request, wait for acceptance, queue its expected words
  task automatic send_req(input int t, input int dest, input int pay, input int id, input int hops,
                          input int energy, input int q, input int r, input int le, input int hd,
                          input bit push, input bit timed);
    bit ok;
    @(posedge clk); #1;
    en = 1'b1; req_valid = 1'b1; req_type = 3'(t);
    req_dest = 16'(dest); req_payload = 16'(pay); myNodeID = 16'(id); hopsFromSink = 16'(hops);
    myEnergy = 16'(energy); myQValue = 16'(q); role = 1'(r); low_E = 1'(le); iHaveData = 1'(hd);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready stayed 0, expected 1");
      req_valid = 1'b0;
    end else begin
      last_acc_cyc = cyc;
      if (push) push_model(t, dest, pay, id, hops, energy, q, r, le, hd, seq_model, cyc, timed);
      seq_model = (seq_model + 1) % 256;
      @(posedge clk); #1;
      req_valid = 1'b0;
      randomize_node();
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
    end
  endtask

  // Monitor: idle zero, hold-while-stalled, and in-order scoreboard on each handshake
  always @(negedge clk) begin
    if (!nrst) begin
      stall_prev = 1'b0;
    end else begin
      if (!tx_valid) begin
        checks++;
        if (tx_data !== 16'h0 || tx_last !== 1'b0) begin
          errors++;
          $display("FAIL idle_zero: data=0x%0h last=%0b expected 0/0", tx_data, tx_last);
        end
      end
      if (stall_prev) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== stall_data || tx_last !== stall_last) begin
          errors++;
          $display("FAIL hold: valid=%0b data=0x%0h expected 1/0x%0h", tx_valid, tx_data, stall_data);
        end
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
      stall_last = tx_last;
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: data=0x%0h with empty scoreboard", tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (tx_data !== mon_e.data || tx_last !== mon_e.last) begin
            errors++;
            $display("FAIL word: data=0x%0h last=%0b expected 0x%0h/%0b", tx_data, tx_last, mon_e.data, mon_e.last);
          end
          if (mon_e.first && mon_e.timed) check("w0_latency", 32'(cyc), 32'(mon_e.acc_cyc + 1));
          if (mon_e.last && mon_e.timed) check("csum_latency", 32'(cyc), 32'(mon_e.acc_cyc + mon_e.len));
          if (mon_e.first && btb && have_last) check("gap", 32'(cyc - last_cyc), 32'd2);
          if (mon_e.last) begin last_cyc = cyc; have_last = btb; end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    logic [15:0] t1 [7];
    exp_t e;
    nrst = 1'b0; en = 1'b1; req_valid = 1'b0; req_type = 3'd0;
    req_dest = '0; req_payload = '0; myNodeID = '0; hopsFromSink = '0;
    myEnergy = '0; myQValue = '0; role = 1'b0; low_E = 1'b0; iHaveData = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_err", 32'(req_err), 32'd0);
    @(posedge clk); #1; nrst = 1'b1;

    // Known-answer heartbeat
    send_req(1, 'hFFFF, 0, 'h0005, 3, 'h0100, 'h0020, 0, 0, 0, 1'b0, 1'b1);
    t1 = '{16'h2000, 16'h0005, 16'hFFFF, 16'h0003, 16'h0100, 16'h0020, 16'hDED9};
    for (int i = 0; i < 7; i++) begin
      e.data = t1[i]; e.first = (i == 0); e.last = (i == 6);
      e.acc_cyc = last_acc_cyc; e.len = 7; e.timed = 1'b1;
      exp_q.push_back(e);
    end
    busy_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      if (n > 0) @(negedge clk);
      else @(negedge clk);
      if (!busy) break;
      busy_cnt++;
    end
    check("busy_cycles", 32'(busy_cnt), 32'd7);
    drain();

    // Data packet with role and low_E set
    send_req(5, 'h1234, 'hABCD, 'h0042, 1, 'h0FFF, 'h7777, 1, 1, 0, 1'b1, 1'b1);
    drain();

    // Stall on W2 for two cycles
    send_req(2, 'h5A5A, 0, 'h0011, 2, 'h0222, 'h0033, 0, 1, 1, 1'b1, 1'b0);
    @(posedge clk); #1; ready_force = 1'b1;
    @(posedge clk); #1; ready_force = 1'b0;
    @(posedge clk); #1; ready_force = 1'b0;
    @(negedge clk);
    check("w2_stalled", 32'(tx_data), 32'h5A5A);
    @(posedge clk); #1; ready_force = 1'b1;
    drain();

    // Illegal type: error pulse, no packet
    @(posedge clk); #1; en = 1'b1; req_valid = 1'b1; req_type = 3'd6;
    @(negedge clk); check("illegal_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); check("req_err_pulse", 32'(req_err), 32'd1);
    check("illegal_busy", 32'(busy), 32'd0);
    @(negedge clk); check("req_err_clear", 32'(req_err), 32'd0);

    // Disabled block ignores requests
    @(posedge clk); #1; en = 1'b0; req_valid = 1'b1; req_type = 3'd1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("en0_ready", 32'(req_ready), 32'd0);
      check("en0_err", 32'(req_err), 32'd0);
      check("en0_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1; req_valid = 1'b0; en = 1'b1;

    // Next legal packet proves seq was untouched by the rejected requests
    send_req(3, 'h0001, 0, 'h0002, 4, 'h0005, 'h0006, 1, 0, 1, 1'b1, 1'b1);
    drain();

    // Reset during W3 aborts the packet and clears seq
    send_req(1, 'h00AA, 0, 'h00BB, 'h00CC, 'h00DD, 'h00EE, 0, 0, 0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("w3_before_reset", 32'(tx_data), 32'h00CC);
    nrst = 1'b0;
    #1;
    check("abort_valid", 32'(tx_valid), 32'd0);
    check("abort_data", 32'(tx_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    seq_model = 0;
    @(posedge clk); #1; nrst = 1'b1;
    send_req(4, 'h0F0F, 0, 'h0101, 7, 'h0202, 'h0303, 1, 1, 1, 1'b1, 1'b1);
    drain();

    // Back-to-back heartbeats through the seq wrap
    btb = 1'b1;
    for (int k = 0; k < 256; k++)
      send_req(1, int'($urandom_range(0, 65535)), 0, int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 65535)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'b1, 1'b1);
    drain();
    btb = 1'b0;

    // Random packets with random backpressure and en dropped mid-packet
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send_req(int'($urandom_range(1, 5)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
               1'b1, 1'b0);
      en = 1'($urandom_range(0, 1));
    end
    drain();
    rand_ready = 1'b0;
    en = 1'b1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
